// File: rtl/divisor_4bits.sv
// divisor_4bits: sequential 4-bit unsigned restoring divider, one quotient bit per clock
module subtrator_4bits (
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic [3:0] S,
    output logic       Bout
);
    logic [4:0] d;
    assign d    = {1'b0, A} - {1'b0, B};
    assign S    = d[3:0];
    assign Bout = d[4];
endmodule

module divisor_4bits (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic [3:0] Q,
    output logic [3:0] R,
    output logic       busy,
    output logic       done,
    output logic       erro_div0
);
    typedef enum logic [1:0] {IDLE, CALC, FIM} state_t;
    state_t state, nxt;
    logic [3:0] wq, wb, wr, s, nr;
    logic [4:0] p;
    logic [1:0] cnt;
    logic       bout, ge;
    subtrator_4bits u_sub (.A(p[3:0]), .B(wb), .S(s), .Bout(bout));
    assign busy = state == CALC;
    assign done = state == FIM;
    // p[4] keeps the step correct for any wr < wb, even though a 4-bit dividend never sets it
    always_comb begin
        p  = {wr, wq[3]};
        ge = p[4] | ~bout;
        nr = ge ? s : p[3:0];
        nxt = state;
        unique case (state)
            IDLE:    nxt = start ? ((B == 4'd0) ? FIM : CALC) : IDLE;
            CALC:    nxt = (cnt == 2'd3) ? FIM : CALC;
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= nxt;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            Q         <= 4'd0;
            R         <= 4'd0;
            erro_div0 <= 1'b0;
            cnt       <= 2'd0;
            wq        <= 4'd0;
            wb        <= 4'd0;
            wr        <= 4'd0;
        end else if (state == IDLE && start) begin
            if (B == 4'd0) begin
                Q         <= 4'hF;
                R         <= A;
                erro_div0 <= 1'b1;
            end else begin
                wq  <= A;
                wb  <= B;
                wr  <= 4'd0;
                cnt <= 2'd0;
            end
        end else if (state == CALC) begin
            wr  <= nr;
            wq  <= {wq[2:0], ge};
            cnt <= cnt + 2'd1;
            if (cnt == 2'd3) begin
                Q         <= {wq[2:0], ge};
                R         <= nr;
                erro_div0 <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_divisor_4bits.sv
// tb_divisor_4bits: scoreboard bench for the sequential divider
module tb_divisor_4bits;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] A = 4'd0;
    logic [3:0] B = 4'd0;
    logic [3:0] Q, R;
    logic       busy, done, erro_div0;
    int         nvec = 0;
    int         nfail = 0;
    logic [8:0] sb[$];

    divisor_4bits dut (
        .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
        .Q(Q), .R(R), .busy(busy), .done(done), .erro_div0(erro_div0)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s got %0d want %0d", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] model(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] q, r;
        if (b == 4'd0) return {4'hF, a, 1'b1};
        q = a / b;
        r = a % b;
        return {q, r, 1'b0};
    endfunction

    // results are popped only when the DUT signals done; any unexpected pulse is an error
    always @(negedge clk) begin
        if (!rst && done) begin
            check("busy_with_done", busy, 0);
            if (sb.size() == 0) begin
                check("spurious_done", 1, 0);
            end else begin
                logic [8:0] e;
                e = sb.pop_front();
                check("Q", Q, e[8:5]);
                check("R", R, e[4:1]);
                check("erro_div0", erro_div0, e[0]);
            end
        end
    end

    // mode 0: pulse start; 1: keep start high; 2: pulse, then drive junk start/A/B during CALC
    task automatic go(input logic [3:0] a, input logic [3:0] b, input int mode);
        int nb, dpos;
        nb = 0;
        dpos = 0;
        @(negedge clk);
        A = a;
        B = b;
        start = 1'b1;
        sb.push_back(model(a, b));
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 1 && mode != 1) start = 1'b0;
            if (i == 2 && mode == 2) begin
                start = 1'b1;
                A = 4'd1;
                B = 4'd1;
            end
            if (busy) nb++;
            if (done) begin
                dpos = i;
                break;
            end
        end
        if (mode == 2) start = 1'b0;
        check("latency", dpos, (b == 4'd0) ? 1 : 5);
        check("busy_cycles", nb, (b == 4'd0) ? 0 : 4);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("reset_state", {Q, R, busy, done, erro_div0}, 0);
        rst = 1'b0;
        go(4'd13, 4'd3, 0);
        go(4'd15, 4'd1, 1);
        go(4'd7, 4'd9, 1);
        go(4'd15, 4'd2, 1);
        start = 1'b0;
        go(4'd9, 4'd0, 0);
        go(4'd6, 4'd3, 0);
        go(4'd12, 4'd5, 2);
        @(negedge clk);
        A = 4'd14;
        B = 4'd4;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_pre_rst", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_state", {Q, R, busy, done, erro_div0}, 0);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("abort_idle", {busy, done}, 0);
        go(4'd14, 4'd4, 0);
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                go(4'(a), 4'(b), 0);
        repeat (8) @(negedge clk);
        check("queue_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
